// File: rtl/hilo_muldiv_seq_pkg.sv
// hilo_muldiv_seq_pkg
//   Shared definitions for the HI/LO multiply/divide sequencer: operation
//   codes, FSM state encodings, divide step count, common constants and the
//   32x32->64 multiply helper shared by MULT and MADD/MSUB.
package hilo_muldiv_seq_pkg;

    localparam int          DIV_STEP_CNT = 32;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        RST_ENABLE   = 1'b1;
    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic        STALL_STOP   = 1'b1;
    localparam logic        STALL_GO     = 1'b0;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_MSUB  = 3'd4,
        OP_MSUBU = 3'd5,
        OP_DIV   = 3'd6,
        OP_DIVU  = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_DIV_ON = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Extending both operands to 64 bits (sign or zero) and keeping the low
    // 64 bits of the product gives the exact signed/unsigned 64-bit result.
    function automatic logic [63:0] mul64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
        logic [63:0] a_ext;
        logic [63:0] b_ext;
        a_ext = {{32{is_signed & a[31]}}, a};
        b_ext = {{32{is_signed & b[31]}}, b};
        return a_ext * b_ext;
    endfunction

endpackage

// File: rtl/hilo_muldiv_seq_div_core.sv
// hilo_muldiv_seq_div_core
//   Radix-2 restoring divider datapath. start_i latches absolute operand
//   values and the result signs; each step_i performs one shift-subtract.
//   quotient_o/remainder_o reflect the state after the step being taken in
//   the current cycle, sign-corrected, so the owner can capture them on the
//   final step.
//   Ports: clk; start_i, signed_i, dividend_i, divisor_i (load);
//          step_i (iterate); quotient_o, remainder_o (results).
module hilo_muldiv_seq_div_core
    import hilo_muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        step_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [32:0] trial;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (ZERO_WORD - v) : v;
    endfunction

    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        trial     = {rem_q, quo_q[31]} - {1'b0, dvs_q};
        if (start_i) begin
            rem_d     = ZERO_WORD;
            quo_d     = abs32(dividend_i, signed_i);
            dvs_d     = abs32(divisor_i, signed_i);
            neg_quo_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
            neg_rem_d = signed_i & dividend_i[31];
        end else if (step_i) begin
            // Borrow out (trial[32]) means the divisor did not fit: restore.
            if (!trial[32]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = {rem_q[30:0], quo_q[31]};
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
        // |-2^31| = 2^31 is still exact as an unsigned magnitude, so
        // -2^31 / -1 yields 32'h80000000 with no special case.
        quotient_o  = neg_quo_q ? (ZERO_WORD - quo_d) : quo_d;
        remainder_o = neg_rem_q ? (ZERO_WORD - rem_d) : rem_d;
    end

    always_ff @(posedge clk) begin
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        dvs_q     <= dvs_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq
//   EX-stage multiply/divide sequencer owning all HI/LO writes. Accepts one
//   MULT/MADD/MSUB/DIV-class operation at a time, stalls the pipeline while
//   busy and emits a one-cycle HI/LO write on completion.
//   Ports: clk, rst (sync, active-high); start_i, op_i, opdata1_i, opdata2_i
//          (request); hi_i, lo_i (forwarded HI/LO for accumulate); annul_i
//          (flush); stallreq_o; hi_o, lo_o, we_o (HI/LO write).
module hilo_muldiv_seq
    import hilo_muldiv_seq_pkg::*;
#(
    parameter int DIV_STEPS = DIV_STEP_CNT,
    parameter int CNT_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        annul_i,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        we_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               we_q, we_d;
    logic [63:0]        prod_q, prod_d;
    logic               acc_sub_q, acc_sub_d;
    logic [63:0]        acc_res;
    logic               div_start;
    logic               div_step;
    logic [31:0]        div_quo;
    logic [31:0]        div_rem;
    logic               go;

    hilo_muldiv_seq_div_core u_div_core (
        .clk         (clk),
        .start_i     (div_start),
        .signed_i    (op_i == OP_DIV),
        .dividend_i  (opdata1_i),
        .divisor_i   (opdata2_i),
        .step_i      (div_step),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign go = start_i & ~annul_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        we_d      = 1'b0;
        prod_d    = prod_q;
        acc_sub_d = acc_sub_q;
        div_start = 1'b0;
        div_step  = 1'b0;
        acc_res   = acc_sub_q ? ({hi_i, lo_i} - prod_q) : ({hi_i, lo_i} + prod_q);

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    case (op_i)
                        OP_MULT, OP_MULTU: begin
                            {hi_d, lo_d} = mul64(opdata1_i, opdata2_i, op_i == OP_MULT);
                            we_d         = WRITE_ENABLE;
                            state_d      = ST_DONE;
                        end
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            prod_d    = mul64(opdata1_i, opdata2_i,
                                              (op_i == OP_MADD) || (op_i == OP_MSUB));
                            acc_sub_d = (op_i == OP_MSUB) || (op_i == OP_MSUBU);
                            state_d   = ST_ACC;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (opdata2_i == ZERO_WORD) begin
                                hi_d    = opdata1_i;
                                lo_d    = 32'hFFFF_FFFF;
                                we_d    = WRITE_ENABLE;
                                state_d = ST_DONE;
                            end else begin
                                div_start = 1'b1;
                                cnt_d     = '0;
                                state_d   = ST_DIV_ON;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_ACC: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    {hi_d, lo_d} = acc_res;
                    we_d         = WRITE_ENABLE;
                    state_d      = ST_DONE;
                end
            end
            ST_DIV_ON: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
                        hi_d    = div_rem;
                        lo_d    = div_quo;
                        we_d    = WRITE_ENABLE;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= ZERO_WORD;
            lo_q    <= ZERO_WORD;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
        end
    end

    // Pure datapath staging; control state alone decides when it is used.
    always_ff @(posedge clk) begin
        prod_q    <= prod_d;
        acc_sub_q <= acc_sub_d;
    end

    // Low in DONE so the pipeline advances during the write cycle.
    assign stallreq_o = (rst == RST_ENABLE) ? STALL_GO :
                        ((state_q == ST_IDLE) & go) |
                        (state_q == ST_ACC) | (state_q == ST_DIV_ON);

    assign hi_o = hi_q;
    assign lo_o = lo_q;
    assign we_o = we_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// tb_hilo_muldiv_seq
//   Directed bench for hilo_muldiv_seq with hand-computed expected values.
module tb_hilo_muldiv_seq;

    localparam logic [2:0] MULT  = 3'd0;
    localparam logic [2:0] MULTU = 3'd1;
    localparam logic [2:0] MADDU = 3'd3;
    localparam logic [2:0] MSUB  = 3'd4;
    localparam logic [2:0] DIV   = 3'd6;
    localparam logic [2:0] DIVU  = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        annul_i;
    logic        stallreq_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        we_o;

    int vectors    = 0;
    int miscompares = 0;
    int lat;
    int stalls;
    int we_seen;

    hilo_muldiv_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .annul_i    (annul_i),
        .stallreq_o (stallreq_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .we_o       (we_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Starts an op from IDLE and returns in the we_o cycle (or after a bound).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hin, input logic [31:0] lin,
                          output int latency, output int stall_cycles);
        op_i = op; opdata1_i = a; opdata2_i = b; hi_i = hin; lo_i = lin;
        start_i = 1'b1;
        #1;
        stall_cycles = int'(stallreq_o);
        tick();
        start_i = 1'b0;
        latency = 1;
        while (we_o !== 1'b1 && latency < 40) begin
            stall_cycles += int'(stallreq_o);
            tick();
            latency++;
        end
    endtask

    // Counts we_o pulses over n cycles.
    task automatic count_we(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            seen += int'(we_o);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; op_i = MULT; opdata1_i = '0; opdata2_i = '0;
        hi_i = '0; lo_i = '0; annul_i = 1'b0;
        tick(); tick();
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_stall", stallreq_o, 0);
        rst = 1'b0;
        tick();

        // MULT -5 x 3 = -15
        run_op(MULT, 32'hFFFF_FFFB, 32'd3, 0, 0, lat, stalls);
        chk("mult_lat", lat, 1);
        chk("mult_stalls", stalls, 1);
        chk("mult_stall_done", stallreq_o, 0);
        chk("mult_res", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
        tick();
        chk("mult_we_pulse", we_o, 0);

        // MADDU 0x1_FFFFFFFF + 2*1 = 0x2_00000001
        run_op(MADDU, 32'd2, 32'd1, 32'd1, 32'hFFFF_FFFF, lat, stalls);
        chk("maddu_lat", lat, 2);
        chk("maddu_stalls", stalls, 2);
        chk("maddu_res", {hi_o, lo_o}, 64'h0000_0002_0000_0001);
        tick();

        // MSUB 0 - 1*1 = -1
        run_op(MSUB, 32'd1, 32'd1, 0, 0, lat, stalls);
        chk("msub_lat", lat, 2);
        chk("msub_res", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // DIVU 100 / 7 = 14 r 2
        run_op(DIVU, 32'd100, 32'd7, 0, 0, lat, stalls);
        chk("divu_lat", lat, 33);
        chk("divu_stalls", stalls, 33);
        chk("divu_stall_done", stallreq_o, 0);
        chk("divu_res", {hi_o, lo_o}, {32'd2, 32'd14});
        tick();
        chk("divu_we_pulse", we_o, 0);

        // DIV -7 / 2 = -3 r -1
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, lat, stalls);
        chk("div_neg_lat", lat, 33);
        chk("div_neg_res", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        tick();

        // DIV 5 / 0
        run_op(DIV, 32'd5, 32'd0, 0, 0, lat, stalls);
        chk("div0_lat", lat, 1);
        chk("div0_res", {hi_o, lo_o}, {32'd5, 32'hFFFF_FFFF});
        tick();

        // DIV -2^31 / -1
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, stalls);
        chk("div_ovf_lat", lat, 33);
        chk("div_ovf_res", {hi_o, lo_o}, {32'd0, 32'h8000_0000});
        tick();

        // start with annul in IDLE: nothing starts
        op_i = MULTU; opdata1_i = 32'd9; opdata2_i = 32'd9;
        start_i = 1'b1; annul_i = 1'b1;
        #1;
        chk("annul_idle_stall", stallreq_o, 0);
        tick();
        start_i = 1'b0; annul_i = 1'b0;
        count_we(4, we_seen);
        chk("annul_idle_we", we_seen, 0);
        chk("annul_idle_res", {hi_o, lo_o}, {32'd0, 32'h8000_0000});

        // annul at DIV_ON step 10, then MULTU the following cycle
        op_i = DIVU; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        #1;
        chk("annul_div_we", we_o, 0);
        chk("annul_div_stall", stallreq_o, 0);
        chk("annul_div_res", {hi_o, lo_o}, {32'd0, 32'h8000_0000});
        run_op(MULTU, 32'd3, 32'd4, 0, 0, lat, stalls);
        chk("multu_lat", lat, 1);
        chk("multu_res", {hi_o, lo_o}, {32'd0, 32'd12});
        tick();

        // reset mid-DIV_ON at counter 12
        op_i = DIVU; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_stall_in", stallreq_o, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_we", we_o, 0);
        chk("rst_mid_stall", stallreq_o, 0);
        chk("rst_mid_res", {hi_o, lo_o}, 64'd0);
        count_we(40, we_seen);
        chk("rst_mid_no_we", we_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
